// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the data-RAM port arbiter.
// Owner encoding tags which requester a pending read belongs to.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_e;

    localparam int RAM_DEPTH = 65;

endpackage

// File: rtl/ram_arb_fairness.sv
// Bounded-starvation tracker: counts CPU grants taken while VGA waits and
// raises starve once the CPU has used up its run.
module ram_arb_fairness #(
    parameter int MAX_CPU_RUN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_gnt,
    input  logic vga_gnt,
    input  logic vga_req,
    output logic starve
);

    localparam int CNT_W = $clog2(MAX_CPU_RUN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_CPU_RUN);

    logic [CNT_W-1:0] run_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == RUN_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
        end else if (vga_gnt || !vga_req) begin
            run_cnt <= '0;
        end else if (cpu_gnt) begin
            run_cnt <= sat_inc(run_cnt);
        end
    end

    assign starve = vga_req && (run_cnt == RUN_MAX);

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port data RAM shared by the CPU data port and the VGA fetcher.
// CPU has priority; the fairness block forces a VGA slot after a bounded run.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DEPTH       = RAM_DEPTH,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic              starve;
    logic              cpu_sel;
    logic              vga_sel;
    logic              acc_p0;
    logic              oor_p0;
    logic [ADDR_W-1:0] addr_p0;
    owner_e            pend_p1;
    logic              oor_p1;
    logic [DATA_W-1:0] rd_byte_p1;
    logic [DATA_W-1:0] cpu_hold_p1;
    logic [DATA_W-1:0] vga_hold_p1;

    ram_arb_fairness #(.MAX_CPU_RUN(MAX_CPU_RUN)) u_fair (
        .clk     (clk),
        .reset   (reset),
        .cpu_gnt (cpu_sel),
        .vga_gnt (vga_sel),
        .vga_req (vga_req),
        .starve  (starve)
    );

    // Stage p0: grant decision and RAM command, same cycle as the request
    always_comb begin
        cpu_sel = !reset && cpu_req && !starve;
        vga_sel = !reset && vga_req && !cpu_sel;
        acc_p0  = cpu_sel || vga_sel;
        addr_p0 = cpu_sel ? cpu_addr : (vga_sel ? vga_addr : '0);
        oor_p0  = acc_p0 && (addr_p0 >= DEPTH_A);
    end

    assign cpu_gnt   = cpu_sel;
    assign vga_gnt   = vga_sel;
    assign mem_en    = acc_p0 && !oor_p0;
    assign mem_we    = mem_en && cpu_sel && cpu_we;
    assign mem_addr  = addr_p0;
    assign mem_wdata = (cpu_sel && cpu_we) ? cpu_wdata : '0;
    assign addr_err  = oor_p0;

    // Stage p1: remember who owns the read now in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_p1 <= OWN_NONE;
            oor_p1  <= 1'b0;
        end else begin
            if (cpu_sel && !cpu_we) begin
                pend_p1 <= OWN_CPU;
            end else if (vga_sel) begin
                pend_p1 <= OWN_VGA;
            end else begin
                pend_p1 <= OWN_NONE;
            end
            oor_p1 <= oor_p0;
        end
    end

    // Reset masks the returning read so an interrupted access never pulses rvalid
    assign rd_byte_p1 = oor_p1 ? '0 : mem_rdata;
    assign cpu_rvalid = !reset && (pend_p1 == OWN_CPU);
    assign vga_rvalid = !reset && (pend_p1 == OWN_VGA);
    assign cpu_rdata  = reset ? '0 : (cpu_rvalid ? rd_byte_p1 : cpu_hold_p1);
    assign vga_rdata  = reset ? '0 : (vga_rvalid ? rd_byte_p1 : vga_hold_p1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_hold_p1 <= '0;
            vga_hold_p1 <= '0;
        end else begin
            if (cpu_rvalid) cpu_hold_p1 <= rd_byte_p1;
            if (vga_rvalid) vga_hold_p1 <= rd_byte_p1;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter with a behavioural RAM and a
// transaction-level reference model of arbitration and read return.
module tb_ram_port_arbiter;

    localparam int DEPTH   = 65;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int MAX_RUN = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt, vga_rvalid;
    logic [DATA_W-1:0] vga_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              addr_err;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CPU_RUN(MAX_RUN)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr),
        .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .addr_err(addr_err)
    );

    // Behavioural single-port synchronous RAM
    logic [DATA_W-1:0] ram [0:DEPTH-1];
    logic [DATA_W-1:0] ram_q = '0;
    always @(posedge clk) begin
        if (mem_en && int'(mem_addr) < DEPTH) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    // Reference model state
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    int                streak;
    int                pend;        // 0 none, 1 cpu, 2 vga
    logic [DATA_W-1:0] pend_data, cpu_hold, vga_hold;
    int                vwait;
    logic              e_cg, e_vg;
    logic              d_cg, d_vg, d_crv, d_vrv;
    logic [DATA_W-1:0] d_crd;
    int                n_chk = 0;
    int                n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return ADDR_W'($urandom_range(DEPTH, 255));
        return ADDR_W'($urandom_range(0, DEPTH - 1));
    endfunction

    // One clock cycle: drive, check against the model, then advance the model
    task automatic step(input logic rst, input logic creq, input logic cwe,
                        input logic [ADDR_W-1:0] caddr, input logic [DATA_W-1:0] cwdata,
                        input logic vreq, input logic [ADDR_W-1:0] vaddr);
        logic              starve_m, cg, vg, acc, oor;
        logic [ADDR_W-1:0] ga;
        reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr;
        cpu_wdata = cwdata; vga_req = vreq; vga_addr = vaddr;
        #2;
        starve_m = (streak == MAX_RUN) && vreq;
        cg  = !rst && creq && !starve_m;
        vg  = !rst && vreq && !cg;
        acc = cg || vg;
        ga  = cg ? caddr : vaddr;
        oor = acc && (int'(ga) >= DEPTH);
        check_val("cpu_gnt", cpu_gnt, cg);
        check_val("vga_gnt", vga_gnt, vg);
        check_val("mem_en", mem_en, acc && !oor);
        check_val("mem_we", mem_we, cg && cwe && !oor);
        check_val("addr_err", addr_err, oor);
        if (acc && !oor) check_val("mem_addr", mem_addr, ga);
        if (cg && cwe && !oor) check_val("mem_wdata", mem_wdata, cwdata);
        check_val("cpu_rvalid", cpu_rvalid, !rst && pend == 1);
        check_val("vga_rvalid", vga_rvalid, !rst && pend == 2);
        check_val("cpu_rdata", cpu_rdata, rst ? '0 : (pend == 1 ? pend_data : cpu_hold));
        check_val("vga_rdata", vga_rdata, rst ? '0 : (pend == 2 ? pend_data : vga_hold));
        if (vreq && !rst) begin
            vwait++;
            if (vga_gnt) begin
                check_val("vga_wait_bound", vwait <= MAX_RUN + 1, 1);
                vwait = 0;
            end
        end else begin
            vwait = 0;
        end
        d_cg = cpu_gnt; d_vg = vga_gnt; d_crv = cpu_rvalid; d_vrv = vga_rvalid; d_crd = cpu_rdata;
        e_cg = cg; e_vg = vg;
        @(posedge clk);
        #1;
        if (rst) begin
            streak = 0; pend = 0; pend_data = '0; cpu_hold = '0; vga_hold = '0;
        end else begin
            if (pend == 1) cpu_hold = pend_data;
            if (pend == 2) vga_hold = pend_data;
            pend = (cg && !cwe) ? 1 : (vg ? 2 : 0);
            pend_data = (acc && !oor) ? ref_mem[ga] : '0;
            if (cg && cwe && !oor) ref_mem[ga] = cwdata;
            if (vg || !vreq) streak = 0;
            else if (cg && streak < MAX_RUN) streak++;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        logic              c_p, c_we, v_p;
        logic [ADDR_W-1:0] c_a, v_a;
        logic [DATA_W-1:0] c_d;
        streak = 0; pend = 0; pend_data = '0; cpu_hold = '0; vga_hold = '0; vwait = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vga_req = 1'b0; vga_addr = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        check_val("reset_mem_addr", mem_addr, 0);
        check_val("reset_mem_wdata", mem_wdata, 0);

        for (int a = 0; a < DEPTH; a++)
            step(1'b0, 1'b1, 1'b1, ADDR_W'(a), DATA_W'($urandom), 1'b0, '0);

        step(1'b0, 1'b1, 1'b1, 8'd5, 8'hA5, 1'b0, '0);
        check_val("wr5_gnt", d_cg, 1);
        step(1'b0, 1'b1, 1'b0, 8'd5, '0, 1'b0, '0);
        check_val("rd5_gnt", d_cg, 1);
        idle();
        check_val("rd5_rvalid", d_crv, 1);
        check_val("rd5_rdata", d_crd, 8'hA5);
        check_val("rd5_vga_quiet", d_vrv, 0);

        for (int a = 0; a < 4; a++) begin
            step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, ADDR_W'(a));
            check_val("vga_b2b_gnt", d_vg, 1);
            if (a > 0) check_val("vga_b2b_rvalid", d_vrv, 1);
        end
        idle();
        check_val("vga_b2b_last_rvalid", d_vrv, 1);

        step(1'b0, 1'b1, 1'b0, 8'd70, '0, 1'b0, '0);
        idle();
        check_val("oor_rvalid", d_crv, 1);
        check_val("oor_rdata", d_crd, 0);
        step(1'b0, 1'b1, 1'b1, 8'd70, 8'h5A, 1'b0, '0);
        idle();

        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0, ADDR_W'($urandom_range(0, DEPTH - 1)), '0,
                 1'b1, ADDR_W'($urandom_range(0, DEPTH - 1)));
            check_val("contention_vga", d_vg, (i % 5) == 4);
            check_val("contention_cpu", d_cg, (i % 5) != 4);
        end
        idle();

        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 8'd7);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0);
        check_val("rst_no_vga_rvalid", d_vrv, 0);
        idle();

        step(1'b0, 1'b1, 1'b0, 8'd10, '0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 8'd11);
        check_val("ilv_cpu_rvalid", d_crv, 1);
        check_val("ilv_vga_quiet", d_vrv, 0);
        idle();
        check_val("ilv_vga_rvalid", d_vrv, 1);
        check_val("ilv_cpu_quiet", d_crv, 0);

        c_p = 1'b0; v_p = 1'b0; c_we = 1'b0; c_a = '0; c_d = '0; v_a = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!c_p && $urandom_range(0, 9) < 7) begin
                c_p = 1'b1; c_we = 1'($urandom_range(0, 1)); c_a = rnd_addr(); c_d = DATA_W'($urandom);
            end
            if (!v_p && $urandom_range(0, 9) < 6) begin
                v_p = 1'b1; v_a = rnd_addr();
            end
            step($urandom_range(0, 199) == 0, c_p, c_we, c_a, c_d, v_p, v_a);
            if (e_cg) c_p = 1'b0;
            if (e_vg) v_p = 1'b0;
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
